// File: rtl/snn_decoder_pkg.sv
// Shared definitions for the SNN output decoder.
// Holds the decoder FSM state type, the default network geometry
// (output neurons and classes) and the widths derived from it.
package snn_decoder_pkg;

  localparam int NUM_OUTPUT_DEF   = 250;
  localparam int NUM_CLASS_DEF    = 10;
  localparam int NEURON_PER_CLASS = NUM_OUTPUT_DEF / NUM_CLASS_DEF;
  localparam int CLASS_W          = $clog2(NUM_CLASS_DEF);
  localparam int VOTE_W           = $clog2(NEURON_PER_CLASS + 1);
  localparam int PACKET_W         = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    GAP,
    ARGMAX,
    DONE
  } dec_state_t;

endpackage

// File: rtl/snn_output_decoder_if.sv
// Read side of the output spike FIFO (first-word-fall-through).
//   packet_out        : head-of-FIFO packet, valid while packet_out_rempty=0
//   packet_out_rempty : FIFO empty
//   packet_out_rinc   : pop strobe, one cycle per packet
// master = FIFO side, slave = decoder side.
interface snn_output_decoder_if;
  import snn_decoder_pkg::*;

  logic [PACKET_W-1:0] packet_out;
  logic                packet_out_rempty;
  logic                packet_out_rinc;

  modport master (
    output packet_out,
    output packet_out_rempty,
    input  packet_out_rinc
  );

  modport slave (
    input  packet_out,
    input  packet_out_rempty,
    output packet_out_rinc
  );

endinterface

// File: rtl/snn_class_argmax.sv
// Sequential argmax over the per-class vote counters.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : start of a new frame; clears scan state and result
//   scan_en      : high while the decoder sits in ARGMAX
//   counts       : per-class vote counters
//   class_id     : winning class (held until the next clear)
//   class_votes  : vote count of the winning class (held until the next clear)
//   done         : high in the cycle the result registers are loaded
// One class is compared per cycle with a strict greater-than, so the
// lowest index wins ties. After the last compare one extra cycle copies
// the running maximum into the result registers.
module snn_class_argmax
  import snn_decoder_pkg::*;
#(
  parameter int NUM_CLASS = NUM_CLASS_DEF,
  parameter int VOTE_BITS = VOTE_W
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         scan_en,
  input  logic [VOTE_BITS-1:0]         counts [NUM_CLASS],
  output logic [$clog2(NUM_CLASS)-1:0] class_id,
  output logic [VOTE_BITS-1:0]         class_votes,
  output logic                         done
);

  localparam int IDX_W = $clog2(NUM_CLASS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     best_idx_q;
  logic [VOTE_BITS-1:0] best_votes_q;
  logic                 commit_q;

  // Running maximum starts at class 0 / 0 votes, which is also the
  // all-zero answer because nothing beats it under strict compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_votes_q <= '0;
      commit_q     <= 1'b0;
      class_id     <= '0;
      class_votes  <= '0;
    end else if (clear) begin
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_votes_q <= '0;
      commit_q     <= 1'b0;
      class_id     <= '0;
      class_votes  <= '0;
    end else if (scan_en) begin
      if (commit_q) begin
        class_id    <= best_idx_q;
        class_votes <= best_votes_q;
        commit_q    <= 1'b0;
        idx_q       <= '0;
      end else begin
        if (counts[idx_q] > best_votes_q) begin
          best_votes_q <= counts[idx_q];
          best_idx_q   <= idx_q;
        end
        if (idx_q == LAST_IDX) begin
          commit_q <= 1'b1;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  assign done = scan_en & commit_q;

endmodule

// File: rtl/snn_output_decoder.sv
// SNN output decoder: drains one frame of output-spike packets from a
// FWFT FIFO, builds the per-neuron fired vector and per-class vote
// counts, then picks the winning class.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : one-cycle pulse, begins a frame (ignored while busy)
//   fifo         : FIFO read port (packet_out, packet_out_rempty, packet_out_rinc)
//   spike_vec    : fired flag per output neuron for the current frame
//   class_id     : winning class
//   class_votes  : votes of the winning class
//   class_valid  : one-cycle result strobe
//   busy         : high whenever the FSM is not IDLE
//   error        : sticky flag for out-of-range packets in this frame
module snn_output_decoder
  import snn_decoder_pkg::*;
#(
  parameter int NUM_OUTPUT = NUM_OUTPUT_DEF,
  parameter int NUM_CLASS  = NUM_CLASS_DEF
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        start,
  snn_output_decoder_if.slave                         fifo,
  output logic [NUM_OUTPUT-1:0]                       spike_vec,
  output logic [$clog2(NUM_CLASS)-1:0]                class_id,
  output logic [$clog2(NUM_OUTPUT/NUM_CLASS+1)-1:0]   class_votes,
  output logic                                        class_valid,
  output logic                                        busy,
  output logic                                        error
);

  localparam int NPC      = NUM_OUTPUT / NUM_CLASS;
  localparam int CID_W    = $clog2(NUM_CLASS);
  localparam int VOTES_W  = $clog2(NPC + 1);
  localparam int NEURON_W = $clog2(NUM_OUTPUT);

  dec_state_t state_q;
  dec_state_t state_d;

  logic [VOTES_W-1:0]  counts_q [NUM_CLASS];
  logic                frame_clear;
  logic                take_packet;
  logic                argmax_done;
  logic                pkt_in_range;
  logic [31:0]         pkt_ext;
  logic [31:0]         neuron_num;
  logic [NEURON_W-1:0] neuron_idx;
  logic [CID_W-1:0]    class_idx;

  // Packet p addresses neuron NUM_OUTPUT-1-p; its class is the neuron
  // index divided by the neurons-per-class (constant divider).
  always_comb begin
    pkt_ext      = 32'(fifo.packet_out);
    pkt_in_range = (pkt_ext < 32'(NUM_OUTPUT));
    neuron_num   = '0;
    if (pkt_in_range) begin
      neuron_num = 32'(NUM_OUTPUT) - 32'd1 - pkt_ext;
    end
    neuron_idx = NEURON_W'(neuron_num);
    class_idx  = CID_W'(neuron_num / 32'(NPC));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Each packet costs READ + GAP; the GAP bubble lets the FIFO head and
  // empty flag settle after the pop before the next sample.
  always_comb begin
    state_d     = state_q;
    frame_clear = 1'b0;
    take_packet = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          frame_clear = 1'b1;
          state_d     = READ;
        end
      end
      READ: begin
        if (!fifo.packet_out_rempty) begin
          take_packet = 1'b1;
          state_d     = GAP;
        end else begin
          state_d = ARGMAX;
        end
      end
      GAP:     state_d = READ;
      ARGMAX:  if (argmax_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fifo.packet_out_rinc = take_packet;
  assign class_valid          = (state_q == DONE);
  assign busy                 = (state_q != IDLE);

  // A neuron votes once per frame: duplicates find its flag already set,
  // which also bounds every counter at NPC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spike_vec <= '0;
      error     <= 1'b0;
      for (int i = 0; i < NUM_CLASS; i++) counts_q[i] <= '0;
    end else if (frame_clear) begin
      spike_vec <= '0;
      error     <= 1'b0;
      for (int i = 0; i < NUM_CLASS; i++) counts_q[i] <= '0;
    end else if (take_packet) begin
      if (!pkt_in_range) begin
        error <= 1'b1;
      end else if (!spike_vec[neuron_idx]) begin
        spike_vec[neuron_idx] <= 1'b1;
        counts_q[class_idx]   <= counts_q[class_idx] + VOTES_W'(1);
      end
    end
  end

  snn_class_argmax #(
    .NUM_CLASS (NUM_CLASS),
    .VOTE_BITS (VOTES_W)
  ) u_argmax (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (frame_clear),
    .scan_en     (state_q == ARGMAX),
    .counts      (counts_q),
    .class_id    (class_id),
    .class_votes (class_votes),
    .done        (argmax_done)
  );

endmodule

// File: tb/tb_snn_output_decoder.sv
// Self-checking bench for snn_output_decoder. A small FWFT FIFO model
// feeds the decoder; each frame's expected result goes onto a
// scoreboard queue when the frame is loaded and is compared when
// class_valid fires.
module tb_snn_output_decoder;
  import snn_decoder_pkg::*;

  localparam int NO = NUM_OUTPUT_DEF;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [NO-1:0]     spike_vec;
  logic [CLASS_W-1:0] class_id;
  logic [VOTE_W-1:0] class_votes;
  logic              class_valid;
  logic              busy;
  logic              error;

  snn_output_decoder_if bus ();

  snn_output_decoder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .fifo        (bus),
    .spike_vec   (spike_vec),
    .class_id    (class_id),
    .class_votes (class_votes),
    .class_valid (class_valid),
    .busy        (busy),
    .error       (error)
  );

  always #5 clk = ~clk;

  // FIFO model: memory and write pointer owned by the stimulus process,
  // read pointer advanced by the DUT pop strobe.
  logic [7:0] fifo_mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cycle_count = 0;

  assign bus.packet_out        = fifo_mem[rd_ptr[7:0]];
  assign bus.packet_out_rempty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (bus.packet_out_rinc && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;
    cycle_count <= cycle_count + 1;
  end

  typedef struct {
    int            cid;
    int            votes;
    bit            err;
    logic [NO-1:0] spikes;
    int            lat;
    int            pops;
  } exp_t;

  typedef struct {
    int n;
    int pkts [32];
    int cid;
    int votes;
    bit err;
  } frame_t;

  exp_t   sb_q [$];
  frame_t frames [8];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     start_cyc;
  int     start_rd;

  task automatic compareInt(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic compareVec(input string name, input logic [NO-1:0] act, input logic [NO-1:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  function automatic frame_t mk(input int cid, input int votes, input bit err, input int n,
                                input int p0 = 0, input int p1 = 0, input int p2 = 0, input int p3 = 0);
    frame_t f;
    f.n = n; f.cid = cid; f.votes = votes; f.err = err;
    for (int i = 0; i < 32; i++) f.pkts[i] = 0;
    f.pkts[0] = p0; f.pkts[1] = p1; f.pkts[2] = p2; f.pkts[3] = p3;
    return f;
  endfunction

  task automatic pushPacket(input int p);
    fifo_mem[wr_ptr[7:0]] = 8'(p);
    wr_ptr++;
  endtask

  task automatic startFrame();
    @(negedge clk);
    start    = 1'b1;
    start_rd = rd_ptr;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cycle_count;
    compareInt("error_cleared_by_start", 32'(error), 32'd0);
    compareInt("busy_after_start", 32'(busy), 32'd1);
    compareVec("spike_vec_cleared_by_start", spike_vec, '0);
  endtask

  // Loads the frame's packets (unless they are already in the FIFO),
  // records the expected result, then pulses start.
  task automatic applyStimulus(input frame_t f, input bit load_fifo);
    exp_t e;
    e.spikes = '0;
    @(negedge clk);
    for (int i = 0; i < f.n; i++) begin
      if (load_fifo) pushPacket(f.pkts[i]);
      if (f.pkts[i] < NO) e.spikes[NO-1-f.pkts[i]] = 1'b1;
    end
    e.cid   = f.cid;
    e.votes = f.votes;
    e.err   = f.err;
    e.pops  = f.n;
    e.lat   = NUM_CLASS_DEF + 2 + 2 * f.n;
    sb_q.push_back(e);
    startFrame();
  endtask

  task automatic checkOutput();
    exp_t e;
    int waited = 0;
    while (class_valid !== 1'b1 && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (class_valid !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL class_valid_timeout: got %0d, expected 1", class_valid);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
      return;
    end
    e = sb_q.pop_front();
    compareInt("latency", 32'(cycle_count - start_cyc), 32'(e.lat));
    compareInt("class_id", 32'(class_id), 32'(e.cid));
    compareInt("class_votes", 32'(class_votes), 32'(e.votes));
    compareInt("error", 32'(error), 32'(e.err));
    compareInt("pops", 32'(rd_ptr - start_rd), 32'(e.pops));
    compareVec("spike_vec", spike_vec, e.spikes);
    @(posedge clk);
    #1;
    compareInt("class_valid_one_cycle", 32'(class_valid), 32'd0);
    compareInt("busy_after_done", 32'(busy), 32'd0);
    compareInt("class_id_held", 32'(class_id), 32'(e.cid));
    compareInt("class_votes_held", 32'(class_votes), 32'(e.votes));
  endtask

  initial begin
    frame_t f;
    int waited;

    reset_n = 1'b1;
    start   = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    $display("[TB] checking reset state");
    compareInt("reset_rinc", 32'(bus.packet_out_rinc), 32'd0);
    compareInt("reset_class_valid", 32'(class_valid), 32'd0);
    compareInt("reset_busy", 32'(busy), 32'd0);
    compareInt("reset_error", 32'(error), 32'd0);
    compareInt("reset_class_id", 32'(class_id), 32'd0);
    compareInt("reset_class_votes", 32'(class_votes), 32'd0);
    compareVec("reset_spike_vec", spike_vec, '0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    frames[0] = mk(0, 0, 1'b0, 0);
    frames[1] = mk(0, 2, 1'b0, 3, 249, 248, 0);
    frames[2] = mk(9, 2, 1'b0, 4, 0, 0, 0, 5);
    frames[3] = mk(0, 1, 1'b0, 2, 249, 0);
    frames[4] = mk(0, 0, 1'b1, 1, 250);
    frames[5] = mk(8, 1, 1'b1, 3, 1, 255, 30);
    frames[6] = mk(5, 3, 1'b0, 4, 100, 101, 102, 3);
    frames[7] = mk(9, 25, 1'b0, 25);
    for (int i = 0; i < 25; i++) frames[7].pkts[i] = i;

    for (int i = 0; i < 8; i++) begin
      $display("[TB] frame %0d with %0d packets", i, frames[i].n);
      applyStimulus(frames[i], 1'b1);
      checkOutput();
    end

    // A packet arriving during ARGMAX stays queued for the next frame.
    $display("[TB] packet arriving during ARGMAX");
    applyStimulus(mk(0, 0, 1'b0, 0), 1'b1);
    repeat (5) @(posedge clk);
    #1;
    pushPacket(7);
    checkOutput();
    compareInt("fifo_left_for_next_frame", 32'(wr_ptr - rd_ptr), 32'd1);
    applyStimulus(mk(9, 1, 1'b0, 1, 7), 1'b0);
    checkOutput();

    // Reset after two of five pops abandons the frame.
    $display("[TB] reset in the middle of a frame");
    @(negedge clk);
    pushPacket(10); pushPacket(20); pushPacket(30); pushPacket(40); pushPacket(45);
    startFrame();
    waited = 0;
    while ((rd_ptr - start_rd) < 2 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    compareInt("pops_before_reset", 32'(rd_ptr - start_rd), 32'd2);
    #1 reset_n = 1'b0;
    #1;
    compareVec("midreset_spike_vec", spike_vec, '0);
    compareInt("midreset_busy", 32'(busy), 32'd0);
    compareInt("midreset_rinc", 32'(bus.packet_out_rinc), 32'd0);
    compareInt("midreset_class_valid", 32'(class_valid), 32'd0);
    compareInt("midreset_class_id", 32'(class_id), 32'd0);
    compareInt("midreset_class_votes", 32'(class_votes), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    compareInt("fifo_left_after_reset", 32'(wr_ptr - rd_ptr), 32'd3);
    @(negedge clk);
    reset_n = 1'b1;
    f = mk(8, 3, 1'b0, 3, 30, 40, 45);
    applyStimulus(f, 1'b0);
    checkOutput();
    compareInt("fifo_empty_at_end", 32'(wr_ptr - rd_ptr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_output_decoder.md
SNN_OUTPUT_DECODER -- requirements
Module: snn_output_decoder

Interface
REQ-001 SHALL have parameter NUM_OUTPUT, default 250, meaning the number of output neurons in the spike vector.
REQ-002 SHALL have parameter NUM_CLASS, default 10, meaning the number of classification classes; NEURON_PER_CLASS = NUM_OUTPUT/NUM_CLASS (25).
REQ-003 SHALL have port clk, input, 1 bit: the single clock. All logic is synchronous to it.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that begins draining one frame.
REQ-006 SHALL have port packet_out, input, 8 bits: output-FIFO head data, in first-word-fall-through format, valid while packet_out_rempty=0.
REQ-007 SHALL have port packet_out_rempty, input, 1 bit: output FIFO empty.
REQ-008 SHALL have port packet_out_rinc, output, 1 bit: FIFO pop, one cycle per packet.
REQ-009 SHALL have port spike_vec, output, NUM_OUTPUT bits: per-neuron fired flags for the current frame.
REQ-010 SHALL have port class_id, output, clog2(NUM_CLASS) bits: winning class.
REQ-011 SHALL have port class_votes, output, clog2(NEURON_PER_CLASS+1) bits: vote count of the winning class.
REQ-012 SHALL have port class_valid, output, 1 bit: one-cycle result strobe.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port error, output, 1 bit: sticky out-of-range packet flag.

Function
REQ-015 SHALL implement the FSM states IDLE, READ, GAP, ARGMAX and DONE.
REQ-016 In IDLE, start=1 SHALL clear spike_vec, all class counters and error, then enter READ; start is ignored while busy=1.
REQ-017 In READ with rempty=0, the block SHALL sample packet_out, assert packet_out_rinc for exactly that cycle, and enter GAP.
REQ-018 In READ with rempty=1, the block SHALL enter ARGMAX with class index 0.
REQ-019 GAP SHALL be one bubble cycle with rinc=0 so that the FIFO head and rempty settle, then return to READ; the cost is 2 cycles per packet.
REQ-020 Packet p < NUM_OUTPUT SHALL map to neuron n = NUM_OUTPUT-1-p and class c = n / NEURON_PER_CLASS.
REQ-021 If spike_vec[n] is 0, the block SHALL set it and increment counter c; a duplicate p SHALL change nothing, so a counter never exceeds NEURON_PER_CLASS.
REQ-022 A packet p >= NUM_OUTPUT SHALL still be popped, SHALL NOT be counted, and SHALL set error until the next accepted start.
REQ-023 ARGMAX SHALL scan one class per cycle (NUM_CLASS cycles) and keep the running maximum under a strict greater-than comparison, so the lowest index wins ties; all-zero counts give class 0 with 0 votes.
REQ-024 DONE SHALL drive class_valid=1 for one cycle with class_id and class_votes stable, then return to IDLE.
REQ-025 class_id, class_votes and spike_vec SHALL hold their values until the next accepted start.
REQ-026 Latency with an empty FIFO SHALL be class_valid high NUM_CLASS+2 cycles after the start edge (12 by default); each popped packet SHALL add 2 cycles.
REQ-027 Packets arriving in the FIFO during ARGMAX or DONE SHALL be left in the FIFO for the next frame.

Reset
REQ-028 Asserting reset_n=0 SHALL asynchronously force IDLE, rinc=0, class_valid=0, busy=0, error=0, spike_vec=0, class_id=0, class_votes=0 and all counters to 0.
REQ-029 Reset mid-frame SHALL abandon the frame without further pops; the first start after release SHALL behave as from power-up.

Structure
REQ-030 A shared package snn_decoder_pkg SHALL hold the state enum, default NUM_OUTPUT/NUM_CLASS, and the derived widths NEURON_PER_CLASS, CLASS_W and VOTE_W.
REQ-031 The design SHALL instantiate one sub-module, snn_class_argmax, containing the sequential scan-and-compare over the counter array.

Verification
REQ-032 Empty FIFO, start pulse -> class_valid at cycle 12, class_id=0, class_votes=0, spike_vec=0, no rinc.
REQ-033 FIFO holds {249,248,0} -> 3 rinc pulses, spike_vec bits 0, 1 and 249 set, counts c0=2 and c9=1, class_id=0, votes=2, class_valid at cycle 18.
REQ-034 FIFO holds {0,0,0,5} -> 4 pops, count c9=2 (duplicates ignored), class_id=9, votes=2.
REQ-035 Tie case, FIFO holds {249,0} -> c0=1 and c9=1, class_id=0; packet 250 -> popped, error=1, not counted, error cleared by the next start.
REQ-036 Assert reset_n=0 after 2 of 5 pops -> outputs zero immediately, 3 packets remain in the FIFO; the following start drains those 3 correctly.
REQ-037 Frame of 25 packets 0..24 -> c9=25, class_id=9, votes=25, counter does not overflow.
